// File: rtl/morph_window_ctrl.sv
// morph_window_ctrl
// Raster sequencer for the 3x3 binary morphology window. Tracks the input and
// output raster positions, primes the line buffers with IMG_W+1 pixels, drains
// them with IMG_W+1 padded shifts and frames the centre-pixel output stream
// under valid/ready backpressure.
module morph_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_sop,
  input  logic i_eop,
  output logic o_ready,
  output logic o_shift_en,
  output logic o_pad,
  output logic o_valid,
  input  logic i_ready,
  output logic o_sop,
  output logic o_eop,
  output logic o_border,
  output logic o_busy,
  output logic o_frame_err
);

  localparam int CNT_W = COL_W + 1;
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  // fill_cnt/pad_cnt hold this value on the shift that completes IMG_W+1
  localparam logic [CNT_W-1:0] PRIME_END = CNT_W'(IMG_W);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t           state;
  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] pad_cnt;
  logic             stall;
  logic             accept;
  logic             in_last;
  logic             out_first;
  logic             out_last;
  logic             emit;

  // Handshake, shift strobe and output-slot decode
  always_comb begin
    stall      = o_valid & ~i_ready;
    o_ready    = ~stall & (state != FLUSH);
    accept     = i_valid & o_ready;
    in_last    = (in_row == LAST_ROW) && (in_col == LAST_COL);
    out_first  = (out_row == '0) && (out_col == '0);
    out_last   = (out_row == LAST_ROW) && (out_col == LAST_COL);
    o_pad      = (state == FLUSH);
    o_busy     = (state != IDLE);
    emit       = 1'b0;
    o_shift_en = 1'b0;
    case (state)
      IDLE:  o_shift_en = accept & i_sop;
      FILL:  o_shift_en = accept;
      RUN: begin
        o_shift_en = accept;
        emit       = accept & ~i_sop;
      end
      FLUSH: begin
        o_shift_en = ~stall;
        emit       = ~stall;
      end
      default: ;
    endcase
  end

  // Sequencer state, raster counters and registered output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_col      <= '0;
      in_row      <= '0;
      out_col     <= '0;
      out_row     <= '0;
      fill_cnt    <= '0;
      pad_cnt     <= '0;
      o_valid     <= 1'b0;
      o_sop       <= 1'b0;
      o_eop       <= 1'b0;
      o_border    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      if (accept && i_sop) begin
        // This pixel becomes (0,0); a sop inside a frame abandons it
        if (state != IDLE) o_frame_err <= 1'b1;
        o_valid  <= 1'b0;
        state    <= FILL;
        in_row   <= '0;
        in_col   <= COL_W'(1);
        fill_cnt <= CNT_W'(1);
        out_row  <= '0;
        out_col  <= '0;
      end else if (accept && state == IDLE) begin
        // Stray pixel outside a frame: dropped without shifting
        o_frame_err <= 1'b1;
      end else if (accept) begin
        if (in_col == LAST_COL) begin
          in_col <= '0;
          in_row <= in_last ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
        // Covers both an early eop and a missing eop on the last pixel
        if (i_eop != in_last) o_frame_err <= 1'b1;
        if (state == FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == PRIME_END) state <= RUN;
        end else if (in_last) begin
          state   <= FLUSH;
          pad_cnt <= '0;
        end
      end else if (state == FLUSH && !stall) begin
        pad_cnt <= pad_cnt + 1'b1;
        if (pad_cnt == PRIME_END) state <= IDLE;
      end

      if (emit) begin
        o_valid  <= 1'b1;
        o_sop    <= out_first;
        o_eop    <= out_last;
        o_border <= (out_row == '0) || (out_row == LAST_ROW) ||
                    (out_col == '0) || (out_col == LAST_COL);
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_last ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morph_window_ctrl.sv
// tb_morph_window_ctrl
// Directed bench for morph_window_ctrl on a 9x6 frame: reset, clean frames,
// border map, output backpressure, mid-frame sop, stray pixels, missing eop.
module tb_morph_window_ctrl;

  localparam int W    = 9;
  localparam int H    = 6;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_sop = 1'b0;
  logic i_eop = 1'b0;
  logic i_ready = 1'b1;
  logic o_ready, o_shift_en, o_pad, o_valid, o_sop, o_eop, o_border, o_busy, o_frame_err;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  morph_window_ctrl #(.IMG_W(W), .IMG_H(H), .COL_W(4), .ROW_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_sop      (i_sop),
    .i_eop      (i_eop),
    .o_ready    (o_ready),
    .o_shift_en (o_shift_en),
    .o_pad      (o_pad),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_border   (o_border),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Border flag expected for raster output index k
  function automatic bit bexp(input int k);
    int r;
    int c;
    r = k / W;
    c = k % W;
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
  endfunction

  // Streams one frame (i_valid every cycle) and scores the output stream
  task automatic run_frame(input int sop_at, input bit drop_eop, input bit do_stall,
                           input int exp_err, input int exp_shifts);
    int   p, exp_idx, nb_cnt, err_cnt, shift_cnt, pad_shift, acc_since_sop, stall_left;
    bit   restarted, stalled, busy_seen, done;
    logic acc;
    p = 0; exp_idx = 0; nb_cnt = 0; err_cnt = 0; shift_cnt = 0; pad_shift = 0;
    acc_since_sop = 0; stall_left = 0;
    restarted = 0; stalled = 0; busy_seen = 0; done = 0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      i_valid = (p < NPIX);
      i_sop   = i_valid && ((p == 0) || (!restarted && p == sop_at));
      i_eop   = i_valid && (p == NPIX - 1) && !drop_eop;
      if (do_stall && !stalled && o_valid && exp_idx == 20) begin
        stalled    = 1;
        stall_left = 5;
      end
      i_ready = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        chk("stall_o_ready", o_ready, 0);
        chk("stall_shift_en", o_shift_en, 0);
        chk("stall_o_valid", o_valid, 1);
        chk("stall_sop_held", o_sop, 0);
        chk("stall_border_held", o_border, bexp(20));
        stall_left--;
      end
      if (o_valid && i_ready) begin
        if (exp_idx == 0) chk("first_out_latency", acc_since_sop, 11);
        chk("out_sop", o_sop, exp_idx == 0);
        chk("out_eop", o_eop, exp_idx == NPIX - 1);
        chk("out_border", o_border, bexp(exp_idx));
        if (!o_border) nb_cnt++;
        exp_idx++;
      end
      if (o_frame_err) err_cnt++;
      if (o_shift_en) shift_cnt++;
      if (o_pad && o_shift_en) pad_shift++;
      if (p >= NPIX && !o_busy && !busy_seen) begin
        busy_seen = 1;
        chk("busy_drop_after_pads", pad_shift, 10);
      end
      if (p >= NPIX && !o_busy && !o_valid) done = 1;
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (i_sop) begin
          acc_since_sop = 1;
          if (p != 0) begin
            restarted = 1;
            exp_idx   = 0;
            nb_cnt    = 0;
          end
          p = 1;
        end else begin
          acc_since_sop++;
          p++;
        end
      end
    end
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
    i_ready = 1'b1;
    chk("frame_completed", done, 1);
    chk("out_count", exp_idx, NPIX);
    chk("interior_count", nb_cnt, 28);
    chk("frame_err_count", err_cnt, exp_err);
    chk("shift_count", shift_cnt, exp_shifts);
    chk("pad_shift_count", pad_shift, 10);
    $display("frame done: sop_at=%0d drop_eop=%0d stall=%0d outputs=%0d errs=%0d shifts=%0d",
             sop_at, drop_eop, do_stall, exp_idx, err_cnt, shift_cnt);
  endtask

  initial begin
    // Test 1: reset values, then reset asserted mid-FILL
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_sop", o_sop, 0);
    chk("rst_o_eop", o_eop, 0);
    chk("rst_o_border", o_border, 0);
    chk("rst_o_frame_err", o_frame_err, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_o_pad", o_pad, 0);
    rst = 1'b0;
    i_valid = 1'b1;
    i_sop   = 1'b1;
    @(posedge clk);
    #1;
    i_sop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fill_busy", o_busy, 1);
    chk("fill_no_valid", o_valid, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_pad", o_pad, 0);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_ready", o_ready, 1);
    $display("reset test done");

    // Tests 2/3: clean frame with border map
    run_frame(-1, 1'b0, 1'b0, 0, 64);
    // Test 4: backpressure at output #20
    run_frame(-1, 1'b0, 1'b1, 0, 64);
    // Test 5: sop re-asserted on the 30th pixel
    run_frame(29, 1'b0, 1'b0, 1, 93);

    // Test 6: stray pixels in IDLE, then a frame missing its eop
    i_valid = 1'b1;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_shift_en", o_shift_en, 0);
      chk("idle_ready", o_ready, 1);
      @(posedge clk);
      #1;
      chk("idle_frame_err", o_frame_err, 1);
      chk("idle_busy", o_busy, 0);
      $display("idle stray pixel %0d: frame_err=%0d busy=%0d", k, o_frame_err, o_busy);
    end
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_err_clears", o_frame_err, 0);
    run_frame(-1, 1'b1, 1'b0, 1, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
